// File: rtl/aes_pkg.sv
// Shared AES key-expansion definitions: widths, round constants and the
// key_sub_word sequencer state encoding.
package aes_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        OUT  = 2'd3
    } ksw_state_t;

    // Index 0 holds 00 so RCON[round] reads naturally for rounds 1..10.
    localparam logic [BYTE_W-1:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [BYTE_W-1:0] rcon_of(input logic [3:0] idx);
        logic [BYTE_W-1:0] r;
        r = '0;
        if (idx >= 4'd1 && idx <= 4'd10) begin
            r = RCON[int'(idx)];
        end
        return r;
    endfunction

endpackage

// File: rtl/key_sub_word.sv
// Computes SubWord(RotWord(w)) ^ Rcon (or SubWord(w) alone) by streaming
// the four bytes of a word through one shared, externally instanced s_box.
module key_sub_word
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic [3:0]        round_idx,
    input  logic              rot_en,
    output logic              busy,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              err,
    output logic              sbox_enable,
    output logic [BYTE_W-1:0] sbox_data_in,
    input  logic [BYTE_W-1:0] sbox_data_out,
    input  logic              sbox_done
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    // s_box handshake: sbox_enable acts as valid and is held with stable
    // sbox_data_in until sbox_done (acting as ready+result-valid) is seen in
    // REQ; that same cycle completes the transfer. Done outside REQ is ignored.
    ksw_state_t        state, state_next;
    logic [1:0]        k;
    logic [TW-1:0]     timer;
    logic [WORD_W-1:0] src;
    logic [WORD_W-1:0] result;
    logic [BYTE_W-1:0] rcon;
    logic [BYTE_W-1:0] cur_byte;
    logic              timeout_hit;

    always_comb begin
        cur_byte = src[31:24];
        case (k)
            2'd0: cur_byte = src[31:24];
            2'd1: cur_byte = src[23:16];
            2'd2: cur_byte = src[15:8];
            2'd3: cur_byte = src[7:0];
            default: cur_byte = src[31:24];
        endcase
    end

    always_comb begin
        state_next   = state;
        timeout_hit  = (state == REQ) && !sbox_done && (timer == TIMER_LAST);
        busy         = (state != IDLE);
        sbox_enable  = (state == REQ);
        sbox_data_in = (state == REQ) ? cur_byte : '0;
        word_valid   = (state == OUT);
        err          = timeout_hit;
        case (state)
            IDLE: if (start) state_next = REQ;
            REQ: begin
                if (sbox_done)        state_next = (k == 2'd3) ? OUT : GAP;
                else if (timeout_hit) state_next = IDLE;
            end
            GAP:     state_next = REQ;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            k        <= 2'd0;
            timer    <= '0;
            src      <= '0;
            rcon     <= '0;
            result   <= '0;
            word_out <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        src   <= rot_en ? {word_in[23:0], word_in[31:24]} : word_in;
                        rcon  <= rot_en ? rcon_of(round_idx) : 8'h00;
                        k     <= 2'd0;
                        timer <= '0;
                    end
                end
                REQ: begin
                    timer <= timer + TIMER_ONE;
                    if (sbox_done) begin
                        case (k)
                            2'd0: result[31:24] <= sbox_data_out;
                            2'd1: result[23:16] <= sbox_data_out;
                            2'd2: result[15:8]  <= sbox_data_out;
                            2'd3: result[7:0]   <= sbox_data_out;
                            default: result <= result;
                        endcase
                        // Load the final word on the edge into OUT so it is
                        // already visible while word_valid is high.
                        if (k == 2'd3) begin
                            word_out <= {result[31:24] ^ rcon, result[23:8], sbox_data_out};
                        end
                    end
                end
                GAP: begin
                    k     <= k + 2'd1;
                    timer <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_sub_word.sv
// Directed bench for key_sub_word with a behavioural s_box of configurable
// latency; expected words are hand-computed from the AES S-box.
module tb_key_sub_word;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] word_in;
    logic [3:0]  round_idx;
    logic        rot_en;
    logic        busy;
    logic [31:0] word_out;
    logic        word_valid;
    logic        err;
    logic        sbox_enable;
    logic [7:0]  sbox_data_in;
    logic [7:0]  sbox_data_out;
    logic        sbox_done;

    int checks   = 0;
    int failures = 0;

    // s_box model controls
    int   lat  = 1;
    logic hang = 1'b0;
    int   en_cnt = 0;

    // per-run observations
    int          cyc_valid, n_valid, cyc_err, n_err, n_bursts, n_gaps, cyc_end;
    logic [31:0] din_seq, got_word;
    logic        expired;

    always #5 clk = ~clk;

    key_sub_word #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .start(start), .word_in(word_in),
        .round_idx(round_idx), .rot_en(rot_en), .busy(busy),
        .word_out(word_out), .word_valid(word_valid), .err(err),
        .sbox_enable(sbox_enable), .sbox_data_in(sbox_data_in),
        .sbox_data_out(sbox_data_out), .sbox_done(sbox_done)
    );

    // Only the S-box entries the vectors touch.
    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        case (b)
            8'h00: return 8'h63;
            8'h01: return 8'h7c;
            8'h02: return 8'h77;
            8'h03: return 8'h7b;
            8'h04: return 8'hf2;
            8'h09: return 8'h01;
            8'h3c: return 8'heb;
            8'h4f: return 8'h84;
            8'hcf: return 8'h8a;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!sbox_enable) en_cnt <= 0;
        else              en_cnt <= en_cnt + 1;
    end

    assign sbox_done     = sbox_enable && !hang && (en_cnt == lat);
    assign sbox_data_out = sbox_lookup(sbox_data_in);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Issues one start at a negedge and watches until busy drops (bounded).
    // restart_at > 0 re-pulses start while that relative cycle is shown.
    task automatic run_word(input logic [31:0] w, input logic [3:0] r, input logic re,
                            input int restart_at);
        logic prev_en;
        word_in   = w;
        round_idx = r;
        rot_en    = re;
        start     = 1'b1;
        cyc_valid = -1; n_valid = 0; cyc_err = -1; n_err = 0;
        n_bursts  = 0;  n_gaps  = 0; cyc_end = -1; din_seq = '0; got_word = '0;
        expired   = 1'b1;
        prev_en   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int rel = 1; rel <= 80; rel++) begin
            if (sbox_enable && !prev_en) begin
                n_bursts++;
                din_seq = {din_seq[23:0], sbox_data_in};
            end
            if (busy && !sbox_enable && !word_valid && !err) n_gaps++;
            if (word_valid) begin
                n_valid++;
                cyc_valid = rel;
                got_word  = word_out;
            end
            if (err) begin
                n_err++;
                cyc_err = rel;
            end
            if (!busy) begin
                cyc_end = rel;
                expired = 1'b0;
                break;
            end
            prev_en = sbox_enable;
            start   = (rel == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        check("run_bounded", {31'd0, expired}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; word_in = '0; round_idx = '0; rot_en = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy",       {31'd0, busy},        32'd0);
        check("rst_word_out",   word_out,             32'd0);
        check("rst_word_valid", {31'd0, word_valid},  32'd0);
        check("rst_err",        {31'd0, err},         32'd0);
        check("rst_sbox_en",    {31'd0, sbox_enable}, 32'd0);
        check("rst_sbox_din",   {24'd0, sbox_data_in}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // FIPS-197 A.1 first expansion step, L=1
        lat = 1;
        run_word(32'h09cf4f3c, 4'd1, 1'b1, 0);
        check("a1_word",      got_word,          32'h8b84eb01);
        check("a1_valid_cyc", cyc_valid,         32'd12);
        check("a1_valid_cnt", n_valid,           32'd1);
        check("a1_bursts",    n_bursts,          32'd4);
        check("a1_gaps",      n_gaps,            32'd3);
        check("a1_din_seq",   din_seq,           32'hcf4f3c09);
        check("a1_busy_end",  cyc_end,           32'd13);
        check("a1_hold",      word_out,          32'h8b84eb01);

        // Round 10 Rcon
        run_word(32'h00000000, 4'd10, 1'b1, 0);
        check("r10_word", got_word, 32'h55636363);

        // SubWord only: no rotation, no Rcon
        run_word(32'h01020304, 4'd5, 1'b0, 0);
        check("sub_word",    got_word, 32'h7c777bf2);
        check("sub_din_seq", din_seq,  32'h01020304);

        // Out-of-range round with rotation: RotWord only, Rcon 00
        run_word(32'h09cf4f3c, 4'd0, 1'b1, 0);
        check("r0_word", got_word, 32'h8a84eb01);

        // L=3 with a second start while busy
        lat = 3;
        run_word(32'h09cf4f3c, 4'd1, 1'b1, 5);
        check("l3_word",      got_word,  32'h8b84eb01);
        check("l3_valid_cyc", cyc_valid, 32'd20);
        check("l3_valid_cnt", n_valid,   32'd1);
        repeat (3) @(negedge clk);
        check("l3_no_restart", {31'd0, busy}, 32'd0);

        // Timeout: s_box never answers
        hang = 1'b1;
        run_word(32'h01020304, 4'd1, 1'b1, 0);
        check("to_err_cnt",   n_err,     32'd1);
        check("to_err_cyc",   cyc_err,   32'd16);
        check("to_busy_end",  cyc_end,   32'd17);
        check("to_valid_cnt", n_valid,   32'd0);
        check("to_word_hold", word_out,  32'h8b84eb01);
        hang = 1'b0;
        lat  = 1;

        // Reset during the byte-2 request
        begin
            int  bursts;
            logic prev_en, hit;
            word_in = 32'h09cf4f3c; round_idx = 4'd1; rot_en = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            bursts = 0; prev_en = 1'b0; hit = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (sbox_enable && !prev_en) bursts++;
                if (bursts == 3 && sbox_enable) begin
                    hit = 1'b1;
                    break;
                end
                prev_en = sbox_enable;
                @(negedge clk);
            end
            check("mid_reached_byte2", {31'd0, hit}, 32'd1);
            reset = 1'b1;
            @(negedge clk);
            check("mid_busy",     {31'd0, busy},         32'd0);
            check("mid_word_out", word_out,              32'd0);
            check("mid_valid",    {31'd0, word_valid},   32'd0);
            check("mid_err",      {31'd0, err},          32'd0);
            check("mid_sbox_en",  {31'd0, sbox_enable},  32'd0);
            check("mid_sbox_din", {24'd0, sbox_data_in}, 32'd0);
            reset = 1'b0;
            @(negedge clk);
        end
        run_word(32'h09cf4f3c, 4'd1, 1'b1, 0);
        check("post_rst_word",      got_word,  32'h8b84eb01);
        check("post_rst_valid_cyc", cyc_valid, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
